ddr5_phy_write_data: RTL

DDR5_PHY_WRITE_DATA -- requirements
Module: ddr5_phy_write_data

---
 rtl/ddr5_phy_pkg.sv | 53 +++++
 rtl/ddr5_phy_crc8.sv | 22 ++
 rtl/ddr5_phy_write_data.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddr5_phy_pkg.sv
// DDR5 PHY write-data path: shared types and constants.
// FSM and burst encodings, burst lengths, CRC-8 polynomial, config decode.
package ddr5_phy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_BURST = 3'd2,
      ST_CRC   = 3'd3,
      ST_POST  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      BURST_BL16 = 2'b00,
      BURST_BC8  = 2'b01,
      BURST_BL32 = 2'b10
   } burst_t;

   localparam logic [4:0] BL16_CYCLES = 5'd8;
   localparam logic [4:0] BC8_CYCLES  = 5'd4;
   localparam logic [4:0] BL32_CYCLES = 5'd16;

   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC_FILL  = 8'hFF;

   // 2'b11 also selects BL32
   function automatic logic [4:0] burst_cycles(input logic [1:0] bl);
      logic [4:0] n;
      case (bl)
         BURST_BL16: n = BL16_CYCLES;
         BURST_BC8:  n = BC8_CYCLES;
         default:    n = BL32_CYCLES;
      endcase
      return n;
   endfunction

   // Index of the last preamble cycle (N-1); out-of-range N acts as 2
   function automatic logic [1:0] pre_end(input logic [2:0] n);
      logic [1:0] e;
      case (n)
         3'd3:    e = 2'd2;
         3'd4:    e = 2'd3;
         default: e = 2'd1;
      endcase
      return e;
   endfunction

   // High when the postamble is two cycles long
   function automatic logic post_end(input logic [1:0] n);
      return n == 2'b10;
   endfunction

endpackage

// File: rtl/ddr5_phy_crc8.sv
// DDR5 write CRC-8 step (poly 0x07), one 16-bit word per call.
// Ports: word (data, bit 15 first), crc_cur (running CRC), crc_nxt (updated CRC).
module ddr5_phy_crc8
   import ddr5_phy_pkg::*;
(
   input  logic [15:0] word,
   input  logic [7:0]  crc_cur,
   output logic [7:0]  crc_nxt
);

   always_comb begin
      crc_nxt = crc_cur;
      for (int i = 15; i >= 0; i--) begin
         if (crc_nxt[7] ^ word[i]) begin
            crc_nxt = {crc_nxt[6:0], 1'b0} ^ CRC8_POLY;
         end else begin
            crc_nxt = {crc_nxt[6:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/ddr5_phy_write_data.sv
// DDR5 PHY write-data serialiser: preamble, burst, optional CRC, postamble.
// Ports:
//   clk_i, rst_i (async, active-low), enable_i (low = hold all state)
//   dfi_wrdata_en_i / dfi_wrdata_i : DFI write word, [15:8] first beat
//   burst_length_i, pre_pattern_i, num_pre_cycle_i, num_post_cycle_i,
//   dram_crc_en_i : burst config, latched on the first word
//   dq_o / dq_oe_o, dqs_o / dqs_oe_o : DQ and strobe drive
//   busy_o : FSM not idle;  err_o : underrun or overlap pulse
module ddr5_phy_write_data
   import ddr5_phy_pkg::*;
#(
   parameter int pFIFO_DEPTH = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        enable_i,
   input  logic        dfi_wrdata_en_i,
   input  logic [15:0] dfi_wrdata_i,
   input  logic [1:0]  burst_length_i,
   input  logic [7:0]  pre_pattern_i,
   input  logic [2:0]  num_pre_cycle_i,
   input  logic [1:0]  num_post_cycle_i,
   input  logic        dram_crc_en_i,
   output logic [15:0] dq_o,
   output logic        dq_oe_o,
   output logic [1:0]  dqs_o,
   output logic        dqs_oe_o,
   output logic        busy_o,
   output logic        err_o
);

   localparam int IW = $clog2(pFIFO_DEPTH);
   localparam int PW = IW + 1;

   state_t state_q, state_d;

   logic [4:0]  blen_q;
   logic [7:0]  pat_q;
   logic [1:0]  pre_end_q;
   logic        post_end_q;
   logic        crc_en_q;

   logic [4:0]  beats_q;
   logic [4:0]  push_cnt_q;
   logic [1:0]  phase_q;
   logic [7:0]  crc_q;
   logic [7:0]  crc_nxt;
   logic        urun_q;

   logic [15:0]   mem [pFIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;

   logic        empty;
   logic [15:0] tx_word;
   logic        accept_new;
   logic        push_more;
   logic        pop;
   logic        pre_last;
   logic        post_last;
   logic        burst_last;
   logic [1:0]  pre_idx;

   // The FIFO is flushed at the start of every burst and one burst never
   // pushes more than 16 words, so the pointers never need to wrap.
   assign empty   = wr_ptr_q == rd_ptr_q;
   assign tx_word = empty ? 16'h0000 : mem[rd_ptr_q[IW-1:0]];

   assign accept_new = enable_i && dfi_wrdata_en_i
                       && state_q == ST_IDLE;
   assign push_more  = enable_i && dfi_wrdata_en_i
                       && (state_q == ST_PRE || state_q == ST_BURST)
                       && push_cnt_q < blen_q;
   assign pop        = enable_i && state_q == ST_BURST && !empty;

   assign pre_last   = phase_q == pre_end_q;
   assign post_last  = phase_q[0] == post_end_q;
   assign burst_last = beats_q == 5'd1;

   // Preamble is sent MSB pair first: cycle k uses pair N-1-k
   assign pre_idx = pre_end_q - phase_q;

   ddr5_phy_crc8 u_crc (
      .word    (tx_word),
      .crc_cur (crc_q),
      .crc_nxt (crc_nxt)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (enable_i) begin
         unique case (state_q)
            ST_IDLE: begin
               if (dfi_wrdata_en_i) state_d = ST_PRE;
            end
            ST_PRE: begin
               if (pre_last) state_d = ST_BURST;
            end
            ST_BURST: begin
               if (burst_last) begin
                  state_d = crc_en_q ? ST_CRC : ST_POST;
               end
            end
            ST_CRC: state_d = ST_POST;
            ST_POST: begin
               if (post_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      dq_o     = 16'h0000;
      dq_oe_o  = 1'b0;
      dqs_o    = 2'b00;
      dqs_oe_o = 1'b0;
      err_o    = 1'b0;
      busy_o   = state_q != ST_IDLE;
      unique case (state_q)
         ST_PRE: begin
            dqs_oe_o = 1'b1;
            dqs_o    = pat_q[{pre_idx, 1'b0} +: 2];
         end
         ST_BURST: begin
            dq_o     = tx_word;
            dq_oe_o  = 1'b1;
            dqs_o    = 2'b10;
            dqs_oe_o = 1'b1;
            // only the first empty beat of a burst is flagged
            err_o    = enable_i && empty && !urun_q;
         end
         ST_CRC: begin
            dq_o     = {crc_q, CRC_FILL};
            dq_oe_o  = 1'b1;
            dqs_o    = 2'b10;
            dqs_oe_o = 1'b1;
            err_o    = enable_i && dfi_wrdata_en_i;
         end
         ST_POST: begin
            dqs_oe_o = 1'b1;
            err_o    = enable_i && dfi_wrdata_en_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         blen_q     <= '0;
         pat_q      <= '0;
         pre_end_q  <= '0;
         post_end_q <= 1'b0;
         crc_en_q   <= 1'b0;
      end else if (accept_new) begin
         blen_q     <= burst_cycles(burst_length_i);
         pat_q      <= pre_pattern_i;
         pre_end_q  <= pre_end(num_pre_cycle_i);
         post_end_q <= post_end(num_post_cycle_i);
         crc_en_q   <= dram_crc_en_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         beats_q    <= '0;
         push_cnt_q <= '0;
         phase_q    <= '0;
         crc_q      <= '0;
         urun_q     <= 1'b0;
      end else if (enable_i) begin
         unique case (state_q)
            ST_IDLE: begin
               if (dfi_wrdata_en_i) begin
                  beats_q    <= burst_cycles(burst_length_i);
                  push_cnt_q <= 5'd1;
                  phase_q    <= '0;
                  crc_q      <= '0;
                  urun_q     <= 1'b0;
               end
            end
            ST_PRE: begin
               phase_q <= pre_last ? 2'd0 : phase_q + 2'd1;
            end
            ST_BURST: begin
               beats_q <= beats_q - 5'd1;
               crc_q   <= crc_nxt;
               if (empty) urun_q <= 1'b1;
            end
            ST_POST: begin
               phase_q <= post_last ? 2'd0 : phase_q + 2'd1;
            end
            default: ;
         endcase
         if (push_more) push_cnt_q <= push_cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (accept_new) begin
         wr_ptr_q <= PW'(1);
         rd_ptr_q <= '0;
      end else begin
         if (push_more) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)       rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept_new) begin
         mem[0] <= dfi_wrdata_i;
      end else if (push_more) begin
         mem[wr_ptr_q[IW-1:0]] <= dfi_wrdata_i;
      end
   end

endmodule
